// File: rtl/fwd_scoreboard_unit.sv
// Scoreboard of in-flight register writes past ID. Produces per-operand forward
// selects and a load-use stall for the ID-stage branch comparator.
module fwd_scoreboard_unit #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int SEL_W    = 2,
  parameter int LAT_W    = 2,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_regwrite,
  input  logic [AW-1:0]    id_wr_addr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             flush,
  output logic             stall,
  output logic [SEL_W-1:0] rd_srcA,
  output logic [SEL_W-1:0] rd_srcB,
  output logic [CNT_W-1:0] stall_count
);

  logic [DEPTH:1]   vld_q;
  logic [DEPTH:1]   rw_q;
  logic [AW-1:0]    addr_q [1:DEPTH];
  logic [LAT_W-1:0] lat_q  [1:DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             vld_d;
  logic [LAT_W-1:0] lat_d;
  logic             haz_a, haz_b;

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  // Scan oldest to youngest so the youngest matching producer is assigned last.
  always_comb begin
    rd_srcA = '0;
    rd_srcB = '0;
    haz_a   = 1'b0;
    haz_b   = 1'b0;
    for (int unsigned i = DEPTH; i >= 1; i--) begin
      if (vld_q[i] && rw_q[i] && addr_q[i] != ZR) begin
        if (addr_q[i] == id_rs) begin
          rd_srcA = SEL_W'(i);
          haz_a   = 32'(lat_q[i]) > i;
        end
        if (addr_q[i] == id_rt) begin
          rd_srcB = SEL_W'(i);
          haz_b   = 32'(lat_q[i]) > i;
        end
      end
    end
  end

  always_comb begin
    stall = id_valid && ((id_uses_rs && haz_a) || (id_uses_rt && haz_b));
    vld_d = id_valid && !stall && !flush;
    lat_d = (id_lat == '0) ? LAT_W'(1) : id_lat;
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      rw_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 1; i <= DEPTH; i++) begin
        addr_q[i] <= '0;
        lat_q[i]  <= '0;
      end
    end else begin
      vld_q[1]  <= vld_d;
      rw_q[1]   <= id_regwrite;
      addr_q[1] <= id_wr_addr;
      lat_q[1]  <= lat_d;
      for (int unsigned i = 2; i <= DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        rw_q[i]   <= rw_q[i-1];
        addr_q[i] <= addr_q[i-1];
        lat_q[i]  <= lat_q[i-1];
      end
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule
